// File: rtl/apple_ctl.sv
// Apple placement controller: draws LFSR candidates, rejects out-of-grid cells,
// confirms each remaining candidate with the snake-occupancy block, then commits the apple.
module apple_ctl #(
  parameter int          GRID_W    = 64,
  parameter int          GRID_H    = 48,
  parameter int          MAX_TRIES = 255,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       head_valid,
  input  logic [6:0] head_x,
  input  logic [5:0] head_y,
  output logic       occ_req,
  output logic [6:0] occ_x,
  output logic [5:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [6:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic       apple_eaten,
  output logic       spawned,
  output logic       grid_full
);

  localparam logic [7:0] GW = 8'(GRID_W);
  localparam logic [6:0] GH = 7'(GRID_H);
  localparam logic [7:0] MT = 8'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, GEN, CHECK, FULL} state_t;

  typedef struct packed {
    logic       occ_req;
    logic [6:0] occ_x;
    logic [5:0] occ_y;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic       apple_valid;
    logic       apple_eaten;
    logic       spawned;
    logic       grid_full;
    logic [7:0] tries;
  } ctl_t;

  state_t      state, nxt_state;
  ctl_t        cur, nxt;
  logic [15:0] lfsr;
  logic [6:0]  cx;
  logic [5:0]  cy;
  logic        in_range;
  logic        eat;
  logic [7:0]  tries_inc;

  // Taps 16,14,13,11 seen from the right-shifting end of the register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign cx        = lfsr[6:0];
  assign cy        = lfsr[13:8];
  assign in_range  = ({1'b0, cx} < GW) && ({1'b0, cy} < GH);
  assign tries_inc = (cur.tries == 8'hFF) ? cur.tries : cur.tries + 8'd1;
  assign eat       = head_valid && cur.apple_valid &&
                     (head_x == cur.apple_x) && (head_y == cur.apple_y);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:  if (eat || start) nxt_state = GEN;
      GEN: begin
        if (in_range)              nxt_state = CHECK;
        else if (tries_inc >= MT)  nxt_state = FULL;
      end
      CHECK: begin
        if (occ_ack) begin
          if (!occ_hit)             nxt_state = IDLE;
          else if (cur.tries >= MT) nxt_state = FULL;
          else                      nxt_state = GEN;
        end
      end
      FULL:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Next values of every registered output; pulses default low.
  always_comb begin
    nxt             = cur;
    nxt.apple_eaten = 1'b0;
    nxt.spawned     = 1'b0;
    case (state)
      IDLE: begin
        if (eat) begin
          nxt.apple_eaten = 1'b1;
          nxt.apple_valid = 1'b0;
          nxt.tries       = '0;
        end else if (start) begin
          nxt.grid_full = 1'b0;
          nxt.tries     = '0;
        end
      end
      GEN: begin
        nxt.tries = tries_inc;
        if (in_range) begin
          nxt.occ_x   = cx;
          nxt.occ_y   = cy;
          nxt.occ_req = 1'b1;
        end
      end
      CHECK: begin
        if (occ_ack) begin
          nxt.occ_req = 1'b0;
          if (!occ_hit) begin
            nxt.apple_x     = cur.occ_x;
            nxt.apple_y     = cur.occ_y;
            nxt.apple_valid = 1'b1;
            nxt.spawned     = 1'b1;
          end
        end
      end
      FULL: begin
        nxt.grid_full   = 1'b1;
        nxt.apple_valid = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) cur <= '0;
    else        cur <= nxt;
  end

  assign occ_req     = cur.occ_req;
  assign occ_x       = cur.occ_x;
  assign occ_y       = cur.occ_y;
  assign apple_x     = cur.apple_x;
  assign apple_y     = cur.apple_y;
  assign apple_valid = cur.apple_valid;
  assign apple_eaten = cur.apple_eaten;
  assign spawned     = cur.spawned;
  assign grid_full   = cur.grid_full;

endmodule

// File: tb/tb_apple_ctl.sv
// Bench for apple_ctl: LFSR-driven candidate search model, randomized handshakes and a
// second small-budget instance for the grid-full path.
module tb_apple_ctl;
  logic       pclk = 1'b0;
  logic       rst_n, start, head_valid, occ_ack, occ_hit;
  logic [6:0] head_x, occ_x, apple_x;
  logic [5:0] head_y, occ_y, apple_y;
  logic       occ_req, apple_valid, apple_eaten, spawned, grid_full;

  logic       start_f, occ_ack_f, occ_hit_f;
  logic [6:0] occ_x_f, apple_x_f;
  logic [5:0] occ_y_f, apple_y_f;
  logic       occ_req_f, apple_valid_f, apple_eaten_f, spawned_f, grid_full_f;

  int          errors = 0, checks = 0, cyc = 0;
  logic [15:0] m = 16'hACE1;
  int          trig_cyc, exp_lat;
  logic [6:0]  ex;
  logic [5:0]  ey;

  always #5 pclk = ~pclk;

  apple_ctl dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .head_valid(head_valid),
    .head_x(head_x), .head_y(head_y), .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .apple_x(apple_x), .apple_y(apple_y),
    .apple_valid(apple_valid), .apple_eaten(apple_eaten), .spawned(spawned),
    .grid_full(grid_full));

  apple_ctl #(.MAX_TRIES(4)) dut_f (
    .pclk(pclk), .rst_n(rst_n), .start(start_f), .head_valid(1'b0),
    .head_x(7'd0), .head_y(6'd0), .occ_req(occ_req_f), .occ_x(occ_x_f), .occ_y(occ_y_f),
    .occ_ack(occ_ack_f), .occ_hit(occ_hit_f), .apple_x(apple_x_f), .apple_y(apple_y_f),
    .apple_valid(apple_valid_f), .apple_eaten(apple_eaten_f), .spawned(spawned_f),
    .grid_full(grid_full_f));

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic bit inr(input logic [15:0] s);
    return (int'(s[6:0]) < 64) && (int'(s[13:8]) < 48);
  endfunction

  // Reference LFSR sequence, cycle-aligned with the DUT.
  always @(posedge pclk or negedge rst_n)
    if (!rst_n) m <= 16'hACE1;
    else        m <= lstep(m);

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called in the cycle whose closing edge triggers a search: first in-range draw after it.
  task automatic set_trigger();
    logic [15:0] v;
    int k;
    v = lstep(m);
    k = 1;
    while (!inr(v) && k < 1000) begin v = lstep(v); k++; end
    ex = v[6:0]; ey = v[13:8]; exp_lat = k + 1; trig_cyc = cyc;
  endtask

  task automatic do_query(input logic hit, input int dly);
    int n;
    logic [6:0] qx;
    logic [5:0] qy;
    n = 0;
    while (!occ_req && n < 300) begin @(negedge pclk); n++; end
    if (!occ_req) begin chk("req_timeout", 0, 1); return; end
    chk("req_lat", cyc - trig_cyc, exp_lat);
    chk("occ_x", occ_x, ex);
    chk("occ_y", occ_y, ey);
    qx = occ_x; qy = occ_y;
    for (int i = 0; i < dly; i++) begin
      @(negedge pclk);
      chk("hold_req", occ_req, 1);
      chk("hold_xy", {occ_x, occ_y}, {qx, qy});
    end
    occ_ack = 1'b1; occ_hit = hit;
    if (hit) set_trigger();
    @(negedge pclk);
    occ_ack = 1'b0; occ_hit = 1'b0;
    chk("req_drop", occ_req, 0);
    if (!hit) begin
      chk("spawned", spawned, 1);
      chk("apple_valid", apple_valid, 1);
      chk("apple_xy", {apple_x, apple_y}, {qx, qy});
    end else begin
      chk("spawned_on_hit", spawned, 0);
    end
  endtask

  task automatic spawn(input int hits, input int dly);
    set_trigger();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    for (int h = 0; h < hits; h++) do_query(1'b1, dly);
    do_query(1'b0, dly);
  endtask

  task automatic eat(input int hits, input int dly);
    logic [6:0] hx;
    logic [5:0] hy;
    hx = apple_x; hy = apple_y;
    set_trigger();
    head_valid = 1'b1; head_x = hx; head_y = hy;
    @(negedge pclk);
    head_valid = 1'b0;
    chk("eaten", apple_eaten, 1);
    chk("eat_valid_drop", apple_valid, 0);
    chk("eat_hold_xy", {apple_x, apple_y}, {hx, hy});
    for (int h = 0; h < hits; h++) do_query(1'b1, dly);
    do_query(1'b0, dly);
  endtask

  // Small-budget model: every in-range draw is queried and acked at once.
  task automatic model_f(input logic [15:0] base, input int hits,
                         output bit full, output int nq, output logic [12:0] xy);
    logic [15:0] v;
    int t;
    v = lstep(base); t = 0; nq = 0; full = 1'b0; xy = '0;
    for (int g = 0; g < 2000; g++) begin
      t++;
      if (inr(v)) begin
        nq++;
        if (nq > hits) begin xy = {v[6:0], v[13:8]}; return; end
        if (t >= 4) begin full = 1'b1; return; end
        v = lstep(lstep(v));
      end else begin
        if (t >= 4) begin full = 1'b1; return; end
        v = lstep(v);
      end
    end
  endtask

  task automatic run_f(input int hits);
    bit          efull, done;
    int          enq, nq;
    logic [12:0] exy, qxy;
    model_f(m, hits, efull, enq, exy);
    start_f = 1'b1;
    @(negedge pclk);
    start_f = 1'b0;
    chk("full_cleared", grid_full_f, 0);
    nq = 0; qxy = '0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (grid_full_f || spawned_f) done = 1'b1;
      else begin
        if (occ_req_f) begin
          nq++;
          occ_ack_f = 1'b1;
          occ_hit_f = (nq <= hits);
          qxy = {occ_x_f, occ_y_f};
        end
        @(negedge pclk);
        occ_ack_f = 1'b0; occ_hit_f = 1'b0;
      end
    end
    chk("f_done", done, 1);
    chk("f_full", grid_full_f, efull);
    chk("f_queries", nq, enq);
    if (efull) chk("f_valid_full", apple_valid_f, 0);
    else begin
      chk("f_valid", apple_valid_f, 1);
      chk("f_apple_xy", {apple_x_f, apple_y_f}, exy);
      chk("f_last_query", qxy, exy);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; head_valid = 1'b0; head_x = '0; head_y = '0;
    occ_ack = 1'b0; occ_hit = 1'b0; start_f = 1'b0; occ_ack_f = 1'b0; occ_hit_f = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("rst_outputs", {occ_req, occ_x, occ_y, apple_x, apple_y, apple_valid,
                        apple_eaten, spawned, grid_full}, 0);

    // Ack with no request outstanding must do nothing.
    occ_ack = 1'b1;
    @(negedge pclk);
    occ_ack = 1'b0;
    chk("stray_ack", {spawned, apple_valid, occ_req}, 0);

    spawn(0, 0);
    chk("ax_range", apple_x < 64, 1);
    chk("ay_range", apple_y < 48, 1);

    spawn(3, 0);

    // Head one row off the apple: no eat.
    head_valid = 1'b1; head_x = apple_x; head_y = apple_y ^ 6'd1;
    @(negedge pclk);
    head_valid = 1'b0;
    chk("miss_no_eat", apple_eaten, 0);
    chk("miss_valid", apple_valid, 1);

    eat(0, 0);

    // Start and eat in the same cycle give exactly one spawn.
    start = 1'b1;
    eat(0, 0);
    start = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      chk("single_spawn", {occ_req, spawned}, 0);
    end

    for (int r = 0; r < 8; r++) begin
      int hits, dly;
      hits = int'($urandom_range(0, 2));
      dly  = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) eat(hits, dly);
      else begin
        @(negedge pclk);
        spawn(hits, dly);
      end
      repeat ($urandom_range(0, 3)) @(negedge pclk);
    end

    spawn(0, 5);

    // Async reset in the middle of a query.
    set_trigger();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    for (int n = 0; n < 300 && !occ_req; n++) @(negedge pclk);
    chk("pre_rst_req", occ_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_req_drop", occ_req, 0);
    chk("rst_mid_outputs", {occ_x, occ_y, apple_x, apple_y, apple_valid, grid_full}, 0);
    @(negedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    chk("post_rst_idle", occ_req, 0);
    spawn(1, 1);

    run_f(1000);
    run_f(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apple_ctl.md
# apple_ctl

Apple placement controller for the snake game. It picks a pseudo-random free grid cell by querying the snake-occupancy logic over a request/acknowledge handshake, and drives `apple_x`/`apple_y` into the apple drawing stage. It also detects when the snake head lands on the apple and then respawns it. It sits between the game-logic/snake-body block and the VGA draw chain, in the `pclk` domain.

## Interface
- `GRID_W`, default 64: playfield width in cells. Range 1..128.
- `GRID_H`, default 48: playfield height in cells. Range 1..64.
- `MAX_TRIES`, default 255: number of candidate draws per spawn before giving up. Range 1..255.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports (name, direction, width, meaning):
- `pclk` in 1: pixel/system clock. The block has one clock; everything is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse requesting a spawn. Used at game start and after `grid_full`.
- `head_valid` in 1: one-cycle pulse; the snake head moved to (`head_x`, `head_y`).
- `head_x` in 7: head column.
- `head_y` in 6: head row.
- `occ_req` out 1: occupancy query request. Registered.
- `occ_x` out 7: queried column. Registered, stable while `occ_req` is high.
- `occ_y` out 6: queried row. Registered, stable while `occ_req` is high.
- `occ_ack` in 1: query answered; `occ_hit` is valid in the same cycle.
- `occ_hit` in 1: 1 means the queried cell is occupied by the snake.
- `apple_x` out 7: apple column, to the draw stage.
- `apple_y` out 6: apple row, to the draw stage.
- `apple_valid` out 1: the apple is placed and should be drawn.
- `apple_eaten` out 1: one-cycle pulse when the head hits a valid apple.
- `spawned` out 1: one-cycle pulse when a new position is committed.
- `grid_full` out 1: sticky; no free cell was found within `MAX_TRIES`.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. Reset value `LFSR_SEED`. Advances every cycle in every state.
- **Candidate:** `cx` = `lfsr[6:0]`, `cy` = `lfsr[13:8]`. The block uses no modulo; it applies rejection sampling instead.
- **FSM states:**
  - **IDLE.** On `start`: clear `grid_full`, clear the try counter, go to GEN. On `head_valid` && `apple_valid` && `head_x==apple_x` && `head_y==apple_y`: pulse `apple_eaten`, clear `apple_valid`, clear the try counter, go to GEN.
  - **GEN.** Each cycle, increment the try counter.
    - If `cx<GRID_W` and `cy<GRID_H`: latch the candidate into `occ_x`/`occ_y`, set `occ_req`, go to CHECK.
    - Else stay in GEN.
    - If the counter reaches `MAX_TRIES` without reaching CHECK, go to FULL.
  - **CHECK.** Hold `occ_req` and the coordinates until `occ_ack`. On the `occ_ack` edge, clear `occ_req`.
    - `occ_hit=0`: `apple_x/apple_y <= occ_x/occ_y`, `apple_valid<=1`, pulse `spawned`, go to IDLE.
    - `occ_hit=1`: if tries==`MAX_TRIES` go to FULL, else go to GEN.
  - **FULL** (lasts one cycle): `grid_full<=1`, `apple_valid<=0`, go to IDLE.
- **Try counter:** 8 bits, saturating. Only in-range candidates reach CHECK, and all candidates count toward `MAX_TRIES`.
- **Ignored inputs:**
  - `head_valid` outside IDLE is ignored; the apple is invalid during a respawn.
  - `start` outside IDLE is ignored.
  - `start` and an eat match in the same IDLE cycle: the eat wins, `apple_eaten` pulses, and a single spawn starts.
- `apple_x/apple_y` hold their old values while `apple_valid=0`.

## Timing
- **Reset values:** `occ_req=0`, `occ_x=0`, `occ_y=0`, `apple_x=0`, `apple_y=0`, `apple_valid=0`, `apple_eaten=0`, `spawned=0`, `grid_full=0`, state IDLE, LFSR=`LFSR_SEED`, try counter 0.
- **Reset mid-operation:** `rst_n` low forces all of the above immediately; `occ_req` drops without waiting for an ack.
- **Minimum spawn latency:**
  - Cycle 0: trigger sampled.
  - Cycle 1: GEN.
  - Cycle 2: CHECK with `occ_req=1`.
  - If `occ_ack` arrives in cycle 2, `apple_valid`=1 and `spawned`=1 are visible in cycle 3.
- **Latency per extra step:** each out-of-range draw adds 1 cycle. Each occupied hit adds 2 cycles plus the ack wait.
- **`occ_ack` rules:** an ack in the first `occ_req` cycle is legal. `occ_ack` while `occ_req=0` is ignored.
- **`apple_eaten` timing:** the pulse is registered and appears in the cycle after the matching `head_valid`. `apple_valid` falls in that same cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → all outputs 0, `occ_req`=0; LFSR sequence starts at 16'hACE1 and matches the reference model.
- **Basic spawn:** `start` pulse; occupancy model always acks in the same cycle with `occ_hit`=0 → `occ_req` rises 2 cycles after `start`; `spawned` and `apple_valid` follow 1 cycle later; `apple_x<64`, `apple_y<48`; coordinates equal the LFSR-model candidate.
- **Occupied retry:** ack the first 3 queries with `occ_hit`=1 → 4 `occ_req` transactions with distinct coordinates; the final committed position equals the 4th query.
- **Eat:** apple at (10,5); `head_valid` with (10,5) → `apple_eaten` pulses once the next cycle, `apple_valid`=0, respawn completes. `head_valid` with (10,6) → no pulse.
- **Grid full:** `MAX_TRIES`=4, `occ_hit` always 1 → `grid_full`=1 and `apple_valid`=0 once the 4th try is rejected. A following `start` clears `grid_full` and spawns normally.
- **Slow ack and async reset:** delay `occ_ack` by 5 cycles → `occ_x/occ_y` stable for all 6 cycles. Assert `rst_n`=0 mid-CHECK → `occ_req` falls immediately; the FSM restarts in IDLE.
